// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared FSM state type and derived address-field widths for the instruction cache.
package instr_cache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ROM_WIDTH = 12;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;
  localparam int OFFSET_BITS = $clog2(DEF_WORDS);
  localparam int INDEX_BITS = $clog2(DEF_LINES);
  localparam int TAG_BITS = DEF_ROM_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
endpackage

// File: rtl/instr_cache_array.sv
// icache_array: data/tag/valid storage with a combinational read port and a synchronous write port.
module icache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  input  logic [$clog2(WORDS)-1:0] rd_off,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [TAG_BITS-1:0]      rd_tag,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic [$clog2(WORDS)-1:0] wr_off,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     tag_en,
  input  logic [TAG_BITS-1:0]      wr_tag,
  input  logic                     set_valid,
  input  logic                     clr_all
);
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  assign rd_data  = data_q[rd_idx][rd_off];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_off] <= wr_data;
    if (tag_en) tag_q[wr_idx] <= wr_tag;
  end
  // Invalidate wins over a same-edge line validation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else if (clr_all) valid_q <= '0;
    else if (set_valid) valid_q[wr_idx] <= 1'b1;
  end
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache with a single-request, multi-beat line refill FSM.
module instr_cache import instr_cache_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROM_WIDTH = DEF_ROM_WIDTH,
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROM_WIDTH-1:0]  a,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  stall,
  input  logic                  inv,
  output logic                  mem_req,
  output logic [ROM_WIDTH-1:0]  mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ROM_WIDTH - IDX_W - OFF_W - 2;
  state_t state_q, state_d;
  logic [TAG_W+IDX_W-1:0] line_q;
  logic [OFF_W-1:0] beat_q;
  logic pend_q, hit, fill_beat, done, unused_bits;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [TAG_W-1:0] arr_tag;
  logic arr_valid;
  assign unused_bits = ^a[1:0];
  icache_array #(.DATA_WIDTH(DATA_WIDTH), .LINES(LINES), .WORDS(WORDS), .TAG_BITS(TAG_W)) u_array (
    .clk(clk),
    .rst(rst),
    .rd_idx(a[OFF_W+2 +: IDX_W]),
    .rd_off(a[2 +: OFF_W]),
    .rd_data(arr_data),
    .rd_tag(arr_tag),
    .rd_valid(arr_valid),
    .wr_en(fill_beat),
    .wr_idx(line_q[IDX_W-1:0]),
    .wr_off(beat_q),
    .wr_data(mem_rdata),
    .tag_en(done),
    .wr_tag(line_q[TAG_W+IDX_W-1 -: TAG_W]),
    .set_valid(done && !pend_q && !inv),
    .clr_all(inv)
  );
  assign hit       = state_q == IDLE && arr_valid && arr_tag == a[ROM_WIDTH-1 -: TAG_W];
  assign fill_beat = state_q == FILL && mem_valid;
  assign done      = fill_beat && beat_q == OFF_W'(WORDS - 1);
  assign rd        = hit ? arr_data : '0;
  assign stall     = !hit;
  assign mem_req   = state_q == REQ;
  assign mem_addr  = mem_req ? {line_q, {(OFF_W + 2){1'b0}}} : '0;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && !hit) ? REQ :
              (state_q == REQ && mem_ready) ? FILL :
              done ? IDLE : state_q;
  end
  // A fence.i during a refill must keep that line from being validated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !hit) line_q <= a[ROM_WIDTH-1 -: TAG_W+IDX_W];
      if (fill_beat) beat_q <= beat_q + OFF_W'(1);
      pend_q <= !done && (pend_q || (inv && state_q != IDLE));
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed and randomized checks of instr_cache against a line-residency reference model.
module tb_instr_cache;
  logic clk = 1'b0, rst = 1'b0, inv = 1'b0, mem_ready = 1'b0, mem_valid = 1'b0;
  logic [11:0] a = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] rd;
  logic stall, mem_req;
  logic [11:0] mem_addr;
  logic [31:0] mem [1024];
  int res [16];
  int phase, m_beat, n_cmp, n_bad;
  bit pend;
  logic [11:0] m_line;
  always #5 clk = ~clk;
  instr_cache dut (
    .clk(clk), .rst(rst), .a(a), .rd(rd), .stall(stall), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset;
    foreach (res[i]) res[i] = -1;
    phase = 0;
    m_beat = 0;
    pend = 0;
    m_line = '0;
  endtask
  // Model: a line is resident or not; a resident line returns backing-memory contents.
  task automatic step(input logic [11:0] ta, input bit ti, input bit tr, input bit tv);
    bit hit;
    logic [11:0] la;
    la = {ta[11:4], 4'h0};
    a = ta; inv = ti; mem_ready = tr; mem_valid = tv;
    mem_rdata = (tv && phase == 2) ? mem[int'(m_line[11:2]) + m_beat] : $urandom;
    #1;
    hit = phase == 0 && res[int'(ta[7:4])] == int'(la);
    chk("stall", 32'(stall), 32'(!hit));
    chk("rd", rd, hit ? mem[ta[11:2]] : 32'h0);
    chk("mem_req", 32'(mem_req), 32'(phase == 1));
    chk("mem_addr", 32'(mem_addr), phase == 1 ? 32'(m_line) : 32'h0);
    if (ti) begin
      foreach (res[i]) res[i] = -1;
      if (phase != 0) pend = 1;
    end
    if (phase == 0 && !hit) begin
      phase = 1;
      m_line = la;
    end else if (phase == 1 && tr) begin
      phase = 2;
      m_beat = 0;
    end else if (phase == 2 && tv) begin
      m_beat++;
      if (m_beat == 4) begin
        if (!pend) res[int'(m_line[7:4])] = int'(m_line);
        phase = 0;
        pend = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic fill(input logic [11:0] ta);
    step(ta, 0, 0, 0);
    step(ta, 0, 1, 0);
    repeat (4) step(ta, 0, 0, 1);
  endtask
  task automatic apply_reset;
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_stall", 32'(stall), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] ra;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h00000013; mem[1] = 32'h00100093; mem[2] = 32'h00200113; mem[3] = 32'h00300193;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_rd", rd, 32'h0);
    chk("reset_stall", 32'(stall), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    step(12'h000, 0, 0, 0);
    step(12'h000, 0, 0, 0);
    step(12'h000, 0, 1, 0);
    repeat (4) step(12'h000, 0, 0, 1);
    step(12'h008, 0, 0, 0);
    chk("first_fill_rd", rd, 32'h00200113);
    chk("first_fill_stall", 32'(stall), 32'h0);
    foreach (ra[i]) ra[i] = 1'b0;
    for (int i = 0; i < 4; i++) step(12'(i * 4), 0, 1, 1);
    fill(12'h100);
    step(12'h000, 0, 0, 0);
    chk("conflict_miss", 32'(mem_req), 32'h1);
    step(12'h000, 0, 1, 0);
    repeat (4) step(12'h000, 0, 0, 1);
    step(12'h200, 0, 0, 0);
    repeat (5) step(12'h200, 0, 0, 0);
    step(12'h200, 0, 1, 0);
    step(12'h200, 0, 0, 1); step(12'h200, 0, 0, 0); step(12'h200, 0, 0, 0);
    step(12'h200, 0, 0, 1); step(12'h200, 0, 0, 1); step(12'h200, 0, 0, 0);
    step(12'h200, 0, 0, 1);
    step(12'h204, 0, 0, 0);
    step(12'h040, 0, 0, 0);
    step(12'h040, 0, 1, 0);
    step(12'h040, 0, 0, 1);
    step(12'h040, 1, 0, 0);
    repeat (3) step(12'h040, 0, 0, 1);
    step(12'h040, 0, 0, 0);
    step(12'h040, 0, 1, 0);
    repeat (4) step(12'h040, 0, 0, 1);
    step(12'h000, 0, 0, 0);
    step(12'h000, 0, 1, 0);
    repeat (4) step(12'h000, 0, 0, 1);
    step(12'h080, 0, 0, 0);
    step(12'h080, 0, 1, 0);
    repeat (2) step(12'h080, 0, 0, 1);
    apply_reset();
    step(12'h080, 0, 0, 0);
    step(12'h080, 0, 0, 0);
    step(12'h080, 0, 1, 0);
    repeat (4) step(12'h080, 0, 0, 1);
    step(12'h084, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (!(phase != 0 && $urandom_range(0, 9) < 8))
        ra = {2'b00, 2'($urandom), 2'b00, 2'($urandom), 4'($urandom)};
      if ($urandom_range(0, 499) == 0) apply_reset();
      step(ra, $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
